decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 53 +++++
 rtl/decode_stage_instr_fields.sv | 37 +++
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcodes, field positions, occupancy encoding.
// Also holds the decoded-field bundle carried with each buffered entry.
package decode_stage_pkg;

   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LUI  = 6'h0F;

   localparam int OPC_LSB = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int SH_LSB  = 6;
   localparam int FN_LSB  = 0;
   localparam int OPC_W   = 6;
   localparam int REG_W   = 5;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_e;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [OPC_W-1:0] funct;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] shamt;
      logic             imm_signed;
      logic             uses_imm;
   } dec_t;

   function automatic logic is_simm_op(input logic [OPC_W-1:0] op);
      return (op == OP_ADDI) || (op == OP_SLTI) ||
             (op == OP_LW)   || (op == OP_SW)   ||
             (op == OP_BEQ)  || (op == OP_BNE);
   endfunction

   function automatic logic is_uimm_op(input logic [OPC_W-1:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) ||
             (op == OP_XORI) || (op == OP_LUI);
   endfunction

endpackage

// File: rtl/decode_stage_instr_fields.sv
// Combinational field split and immediate-class decode of one instruction.
// Used on the accept side so entries are stored already decoded.
module instr_fields
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] instr,
   output dec_t            dec
);

   logic [OPC_W-1:0] op;

   assign op = instr[OPC_LSB +: OPC_W];

   always_comb begin
      dec            = '0;
      dec.opcode     = op;
      dec.funct      = instr[FN_LSB +: OPC_W];
      dec.rs         = instr[RS_LSB +: REG_W];
      dec.rt         = instr[RT_LSB +: REG_W];
      dec.rd         = instr[RD_LSB +: REG_W];
      dec.shamt      = instr[SH_LSB +: REG_W];
      unique case (1'b1)
         is_simm_op(op): begin
            dec.uses_imm   = 1'b1;
            dec.imm_signed = 1'b1;
         end
         is_uimm_op(op): begin
            dec.uses_imm   = 1'b1;
            dec.imm_signed = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: two-entry skid buffer between fetch and execute.
// Entries are decoded on accept; the head entry drives all out_* fields.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IMM_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       out_opcode,
   output logic [5:0]       out_funct,
   output logic [4:0]       out_rs,
   output logic [4:0]       out_rt,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_shamt,
   output logic [IMM_W-1:0] out_imm,
   output logic             out_imm_signed,
   output logic             out_uses_imm,
   output logic [XLEN-1:0]  out_pc,
   output logic [31:0]      decoded_count
);

   typedef struct packed {
      dec_t             dec;
      logic [IMM_W-1:0] imm;
      logic [XLEN-1:0]  pc;
   } entry_t;

   occ_e   state_q;
   occ_e   state_d;
   entry_t head_q;
   entry_t tail_q;
   entry_t new_e;
   dec_t   new_dec;
   logic   in_fire;
   logic   out_fire;
   logic [31:0] count_q;

   instr_fields #(
      .XLEN (XLEN)
   ) u_fields (
      .instr (in_instr),
      .dec   (new_dec)
   );

   assign new_e.dec = new_dec;
   assign new_e.imm = in_instr[IMM_W-1:0];
   assign new_e.pc  = in_pc;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_ONE;
            ST_ONE: begin
               if (in_fire && !out_fire)      state_d = ST_FULL;
               else if (!in_fire && out_fire) state_d = ST_EMPTY;
            end
            ST_FULL:  if (out_fire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // Handshake flags decode the occupancy register only, so in_ready
   // never sees out_ready combinationally.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         ST_ONE: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
         end
         ST_FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else if (!flush) begin
         unique case (state_q)
            ST_EMPTY: if (in_fire) head_q <= new_e;
            ST_ONE: begin
               if (in_fire && out_fire) head_q <= new_e;
               else if (in_fire)        tail_q <= new_e;
            end
            ST_FULL:  if (out_fire) head_q <= tail_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset)         count_q <= '0;
      else if (out_fire) count_q <= count_q + 32'd1;
   end

   assign out_opcode     = head_q.dec.opcode;
   assign out_funct      = head_q.dec.funct;
   assign out_rs         = head_q.dec.rs;
   assign out_rt         = head_q.dec.rt;
   assign out_rd         = head_q.dec.rd;
   assign out_shamt      = head_q.dec.shamt;
   assign out_imm        = head_q.imm;
   assign out_imm_signed = head_q.dec.imm_signed;
   assign out_uses_imm   = head_q.dec.uses_imm;
   assign out_pc         = head_q.pc;
   assign decoded_count  = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_decode_stage;

   localparam int XLEN  = 32;
   localparam int IMM_W = 16;

   logic             clock;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_instr;
   logic [XLEN-1:0]  in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [5:0]       out_opcode;
   logic [5:0]       out_funct;
   logic [4:0]       out_rs;
   logic [4:0]       out_rt;
   logic [4:0]       out_rd;
   logic [4:0]       out_shamt;
   logic [IMM_W-1:0] out_imm;
   logic             out_imm_signed;
   logic             out_uses_imm;
   logic [XLEN-1:0]  out_pc;
   logic [31:0]      decoded_count;

   int errors = 0;
   int checks = 0;
   bit en_cmp = 0;

   decode_stage #(
      .XLEN  (XLEN),
      .IMM_W (IMM_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_instr       (in_instr),
      .in_pc          (in_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_opcode     (out_opcode),
      .out_funct      (out_funct),
      .out_rs         (out_rs),
      .out_rt         (out_rt),
      .out_rd         (out_rd),
      .out_shamt      (out_shamt),
      .out_imm        (out_imm),
      .out_imm_signed (out_imm_signed),
      .out_uses_imm   (out_uses_imm),
      .out_pc         (out_pc),
      .decoded_count  (decoded_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [15:0] imm;
      logic        sg;
      logic        ui;
      logic [31:0] pc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mcount;
   bit          fresh;

   function automatic exp_t model_dec(input logic [31:0] i,
                                      input logic [31:0] pc);
      exp_t e;
      e.op  = i[31:26];
      e.rs  = i[25:21];
      e.rt  = i[20:16];
      e.rd  = i[15:11];
      e.sh  = i[10:6];
      e.fn  = i[5:0];
      e.imm = i[15:0];
      e.pc  = pc;
      e.sg  = 1'b0;
      e.ui  = 1'b0;
      case (e.op)
         6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05: begin
            e.sg = 1'b1;
            e.ui = 1'b1;
         end
         6'h0C, 6'h0D, 6'h0E, 6'h0F: e.ui = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // Reference model: a FIFO of at most two decoded entries.
   initial begin
      bit   inf;
      bit   outf;
      exp_t d;
      forever begin
         @(posedge clock);
         inf  = in_valid && (q.size() < 2);
         outf = out_ready && (q.size() > 0);
         if (reset) begin
            q.delete();
            mcount = 32'd0;
            fresh  = 1'b1;
         end else begin
            if (outf) begin
               d = q.pop_front();
               mcount = mcount + 32'd1;
            end
            if (flush) begin
               q.delete();
            end else if (inf) begin
               q.push_back(model_dec(in_instr, in_pc));
               fresh = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (en_cmp) begin
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("count", decoded_count, mcount);
            if (q.size() > 0) begin
               chk("opcode", 32'(out_opcode), 32'(q[0].op));
               chk("funct", 32'(out_funct), 32'(q[0].fn));
               chk("rs", 32'(out_rs), 32'(q[0].rs));
               chk("rt", 32'(out_rt), 32'(q[0].rt));
               chk("rd", 32'(out_rd), 32'(q[0].rd));
               chk("shamt", 32'(out_shamt), 32'(q[0].sh));
               chk("imm", 32'(out_imm), 32'(q[0].imm));
               chk("imm_signed", 32'(out_imm_signed), 32'(q[0].sg));
               chk("uses_imm", 32'(out_uses_imm), 32'(q[0].ui));
               chk("pc", out_pc, q[0].pc);
            end else if (fresh) begin
               chk("rst_fields", {out_opcode, out_funct, out_rs, out_rt,
                                  out_rd, out_shamt[3:0]}, 32'd0);
               chk("rst_imm", {out_imm, 14'd0, out_imm_signed,
                               out_uses_imm}, 32'd0);
               chk("rst_pc", out_pc, 32'd0);
            end
         end
      end
   end

   function automatic logic [31:0] rand_instr();
      logic [5:0]  ops [12];
      logic [31:0] i;
      ops = '{6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05,
              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h00, 6'h3F};
      i = $urandom;
      i[31:26] = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                             : ops[$urandom_range(0, 11)];
      return i;
   endfunction

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      repeat (2) tick();
      reset  = 1'b0;
      en_cmp = 1'b1;
      chk("lit_rst_in_ready", 32'(in_ready), 32'd1);
      chk("lit_rst_out_valid", 32'(out_valid), 32'd0);
      chk("lit_rst_count", decoded_count, 32'd0);
      chk("lit_rst_opcode", 32'(out_opcode), 32'd0);

      // single addi
      in_valid  = 1'b1;
      in_instr  = 32'h2108FFFF;
      in_pc     = 32'h100;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lit_addi_valid", 32'(out_valid), 32'd1);
      chk("lit_addi_op", 32'(out_opcode), 32'h08);
      chk("lit_addi_rs", 32'(out_rs), 32'd8);
      chk("lit_addi_rt", 32'(out_rt), 32'd8);
      chk("lit_addi_imm", 32'(out_imm), 32'hFFFF);
      chk("lit_addi_sg", 32'(out_imm_signed), 32'd1);
      chk("lit_addi_ui", 32'(out_uses_imm), 32'd1);
      tick();
      chk("lit_addi_count", decoded_count, 32'd1);

      // back-pressure fills both entries, then drains in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h3508000F;
      in_pc     = 32'h104;
      tick();
      in_instr  = 32'h00851020;
      in_pc     = 32'h108;
      tick();
      in_valid = 1'b0;
      chk("lit_full_in_ready", 32'(in_ready), 32'd0);
      chk("lit_ori_op", 32'(out_opcode), 32'h0D);
      tick();
      chk("lit_hold_imm", 32'(out_imm), 32'h000F);
      out_ready = 1'b1;
      chk("lit_ori_sg", 32'(out_imm_signed), 32'd0);
      chk("lit_ori_ui", 32'(out_uses_imm), 32'd1);
      tick();
      chk("lit_add_op", 32'(out_opcode), 32'h00);
      chk("lit_add_fn", 32'(out_funct), 32'h20);
      chk("lit_add_rd", 32'(out_rd), 32'd2);
      chk("lit_add_ui", 32'(out_uses_imm), 32'd0);
      tick();
      chk("lit_drain_valid", 32'(out_valid), 32'd0);
      chk("lit_drain_count", decoded_count, 32'd3);

      // streaming: one per cycle
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         in_instr = rand_instr();
         in_pc    = 32'h1000 + 32'(k * 4);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("lit_stream_count", decoded_count, 32'd103);

      // flush while full with an incoming instruction
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h8C010004;
      tick();
      in_instr  = 32'hAC020008;
      tick();
      flush    = 1'b1;
      in_instr = 32'h10000001;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("lit_flush_valid", 32'(out_valid), 32'd0);
      chk("lit_flush_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_instr  = 32'h3C011234;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lit_post_flush_op", 32'(out_opcode), 32'h0F);
      tick();

      // counter wrap
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h2002FFFE;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #2;
      force dut.count_q = 32'hFFFFFFFF;
      mcount = 32'hFFFFFFFF;
      #1;
      release dut.count_q;
      tick();
      chk("lit_wrap_count", decoded_count, 32'd0);

      // reset while full and transfers requested
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h28030007;
      tick();
      in_instr  = 32'h38040009;
      tick();
      reset     = 1'b1;
      out_ready = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("lit_mrst_ready", 32'(in_ready), 32'd1);
      chk("lit_mrst_valid", 32'(out_valid), 32'd0);
      chk("lit_mrst_count", decoded_count, 32'd0);
      chk("lit_mrst_op", 32'(out_opcode), 32'd0);
      chk("lit_mrst_pc", out_pc, 32'd0);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         reset     = ($urandom_range(0, 200) == 0);
         in_instr  = rand_instr();
         in_pc     = $urandom;
         tick();
      end
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
